// File: rtl/vregfile_pkg.sv
// vregfile_pkg: shared types for the vector register file slice.
//   - default geometry (LANES, VREGS, VREG_WIDTH, NRD) and derived IDX_W
//   - vreg_idx_t / lane_t / vreg_t element types
//   - vrf_state_e: CLEAR (post-reset zeroing sweep) / READY (normal service)
package vregfile_pkg;

    localparam int unsigned LANES_DEF      = 4;
    localparam int unsigned VREGS_DEF      = 32;
    localparam int unsigned VREG_WIDTH_DEF = 32;
    localparam int unsigned NRD_DEF        = 2;
    localparam int unsigned IDX_W          = $clog2(VREGS_DEF);

    typedef logic [IDX_W-1:0]          vreg_idx_t;
    typedef logic [VREG_WIDTH_DEF-1:0] lane_t;
    typedef lane_t [LANES_DEF-1:0]     vreg_t;

    typedef enum logic {
        CLEAR,
        READY
    } vrf_state_e;

endpackage

// File: rtl/vregfile_mp_if.sv
// vregfile_mp_if: request/response bundle between the issue/writeback side (master)
// and the register file (slave).
//   read  : rd_valid, rd_idx -> rd_data, rd_data_valid, rd_ready
//   write : wr_valid, wr_idx, wr_mask, wr_data -> wr_ready
//   rsv   : rsv_valid, rsv_idx -> busy (scoreboard, one bit per register)
interface vregfile_mp_if #(
    parameter int unsigned LANES      = 4,
    parameter int unsigned VREGS      = 32,
    parameter int unsigned VREG_WIDTH = 32,
    parameter int unsigned NRD        = 2,
    parameter int unsigned IDX_W      = $clog2(VREGS)
);
    logic [NRD-1:0]                             rd_valid;
    logic [NRD-1:0][IDX_W-1:0]                  rd_idx;
    logic [NRD-1:0][LANES-1:0][VREG_WIDTH-1:0]  rd_data;
    logic [NRD-1:0]                             rd_data_valid;
    logic                                       rd_ready;

    logic                                       wr_valid;
    logic [IDX_W-1:0]                           wr_idx;
    logic [LANES-1:0]                           wr_mask;
    logic [LANES-1:0][VREG_WIDTH-1:0]           wr_data;
    logic                                       wr_ready;

    logic                                       rsv_valid;
    logic [IDX_W-1:0]                           rsv_idx;
    logic [VREGS-1:0]                           busy;

    modport master (
        output rd_valid, rd_idx, wr_valid, wr_idx, wr_mask, wr_data, rsv_valid, rsv_idx,
        input  rd_data, rd_data_valid, rd_ready, wr_ready, busy
    );

    modport slave (
        input  rd_valid, rd_idx, wr_valid, wr_idx, wr_mask, wr_data, rsv_valid, rsv_idx,
        output rd_data, rd_data_valid, rd_ready, wr_ready, busy
    );

endinterface

// File: rtl/vregfile_mp_clear_seq.sv
// vrf_clear_seq: post-reset zeroing sequencer.
//   clk, rst_n : clock, synchronous active-low reset
//   clr_we     : write all-zero lanes to clr_idx this cycle
//   clr_idx    : register being cleared
//   ready      : sweep finished, array may serve reads/writes/reservations
module vrf_clear_seq
    import vregfile_pkg::*;
#(
    parameter int unsigned VREGS = 32,
    parameter int unsigned IDX_W = $clog2(VREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             clr_we,
    output logic [IDX_W-1:0] clr_idx,
    output logic             ready
);

    vrf_state_e       state_q, state_d;
    logic [IDX_W-1:0] clr_ptr_q, clr_ptr_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        clr_we    = 1'b0;
        ready     = 1'b0;
        unique case (state_q)
            CLEAR: begin
                clr_we    = 1'b1;
                clr_ptr_d = clr_ptr_q + IDX_W'(1);
                // Leave on the edge that clears the last register.
                if (clr_ptr_q == IDX_W'(VREGS - 1)) begin
                    state_d = READY;
                end
            end
            READY: begin
                ready = 1'b1;
            end
        endcase
    end

    assign clr_idx = clr_ptr_q;

endmodule

// File: rtl/vregfile_mp.sv
// vregfile_mp: multi-port vector register file with per-lane masked write and busy scoreboard.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : vregfile_mp_if.slave
//                NRD registered read ports (1-cycle latency, data held while not valid),
//                one masked write port, one reservation port, busy[VREGS] scoreboard.
// After reset the array is zeroed one register per cycle; until then rd_ready/wr_ready are
// low and all requests are ignored.
// Build option VRF_BYPASS_EN: same-edge read of the register being written returns the new
// data for masked lanes (write-first). Undefined: read returns the pre-write value.
module vregfile_mp
    import vregfile_pkg::*;
#(
    parameter int unsigned LANES      = 4,
    parameter int unsigned VREGS      = 32,
    parameter int unsigned VREG_WIDTH = 32,
    parameter int unsigned NRD        = 2,
    parameter int unsigned IDX_W      = $clog2(VREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    vregfile_mp_if.slave  bus
);

    typedef logic [LANES-1:0][VREG_WIDTH-1:0] vrow_t;

    logic             clr_we;
    logic [IDX_W-1:0] clr_idx;
    logic             ready;

    vrow_t            regs_q [VREGS];
    vrow_t [NRD-1:0]  rd_data_q;
    vrow_t [NRD-1:0]  rd_next;
    logic [NRD-1:0]   rd_data_valid_q;
    logic [VREGS-1:0] busy_q, busy_d;
    logic             wr_fire;
    logic             rsv_fire;

    vrf_clear_seq #(
        .VREGS (VREGS),
        .IDX_W (IDX_W)
    ) u_clear_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_we  (clr_we),
        .clr_idx (clr_idx),
        .ready   (ready)
    );

    assign wr_fire  = ready & rst_n & bus.wr_valid;
    assign rsv_fire = ready & bus.rsv_valid;

    // Array carries no reset of its own; the clear sweep zeroes it.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            regs_q[clr_idx] <= '0;
        end else if (wr_fire) begin
            for (int l = 0; l < LANES; l++) begin
                if (bus.wr_mask[l]) begin
                    regs_q[bus.wr_idx][l] <= bus.wr_data[l];
                end
            end
        end
    end

    always_comb begin
        rd_next = '0;
        for (int p = 0; p < NRD; p++) begin
            rd_next[p] = regs_q[bus.rd_idx[p]];
`ifdef VRF_BYPASS_EN
            for (int l = 0; l < LANES; l++) begin
                if (wr_fire && bus.wr_mask[l] && (bus.wr_idx == bus.rd_idx[p])) begin
                    rd_next[p][l] = bus.wr_data[l];
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q       <= '0;
            rd_data_valid_q <= '0;
        end else begin
            for (int p = 0; p < NRD; p++) begin
                rd_data_valid_q[p] <= ready & bus.rd_valid[p];
                if (ready && bus.rd_valid[p]) begin
                    rd_data_q[p] <= rd_next[p];
                end
            end
        end
    end

    // Set is applied after clear so a same-edge reserve wins over the write.
    always_comb begin
        busy_d = busy_q;
        if (wr_fire) begin
            busy_d[bus.wr_idx] = 1'b0;
        end
        if (rsv_fire) begin
            busy_d[bus.rsv_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign bus.rd_data       = rd_data_q;
    assign bus.rd_data_valid = rd_data_valid_q;
    assign bus.rd_ready      = ready;
    assign bus.wr_ready      = ready;
    assign bus.busy          = busy_q;

endmodule
